// File: rtl/stream_length_finder.sv
// Purpose : length of a null-terminated byte string streamed as BYTES-wide words.
// Latency : result is valid from the edge that accepts the terminating word.
// Backpressure: holds the result until len_ready; no input is taken while a result is pending.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    word handshake; in_word byte k = in_word[8k+7:8k], byte 0 scanned first
//   len_valid/len_ready  result handshake; length = bytes before the first 0x00
//   overflow             true length exceeded 2^LEN_W-1 (only with STREAM_LEN_SATURATE_EN)
//
// Build option: STREAM_LEN_SATURATE_EN -- saturate acc/length and report overflow;
// otherwise arithmetic wraps modulo 2^LEN_W and overflow is tied low.
module stream_length_finder #(
    parameter int BYTES = 8,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*BYTES-1:0]   in_word,
    output logic                 len_valid,
    input  logic                 len_ready,
    output logic [LEN_W-1:0]     length,
    output logic                 overflow
);

    // The saturating build needs one extra sum bit to see the carry out.
`ifdef STREAM_LEN_SATURATE_EN
    localparam int SW = LEN_W + 1;
`else
    localparam int SW = LEN_W;
`endif

    typedef enum logic {SCAN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             found;
    logic [SW-1:0]    z;
    logic [SW-1:0]    addend;
    logic [SW-1:0]    sum;
    logic [LEN_W-1:0] acc_next;

    // Lowest zero byte wins; bytes above it are never looked at.
    always_comb begin
        found = 1'b0;
        z     = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (!found && in_word[8*k +: 8] == 8'h00) begin
                found = 1'b1;
                z     = SW'(k);
            end
        end
    end

    assign addend = found ? z : SW'(BYTES);
    assign sum    = SW'(acc_q) + addend;

`ifdef STREAM_LEN_SATURATE_EN
    logic carry;
    assign carry    = sum[LEN_W];
    assign acc_next = carry ? '1 : sum[LEN_W-1:0];
`else
    assign acc_next = sum;
`endif

    // Next-state and handshake outputs. in_ready is a function of state and rst only.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        acc_d    = acc_q;
        len_d    = len_q;
        case (state_q)
            SCAN: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    if (found) begin
                        len_d   = acc_next;
                        acc_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d   = acc_next;
                    end
                end
            end
            HOLD: begin
                if (len_ready) begin
                    state_d = SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            acc_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
        end
    end

    assign len_valid = (state_q == HOLD);
    assign length    = len_q;

`ifdef STREAM_LEN_SATURATE_EN
    // Sticky across all words of a string; cleared when the result is taken.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == SCAN && in_valid && in_ready && carry) begin
            ovf_d = 1'b1;
        end
        if (state_q == HOLD && len_ready) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stream_length_finder.sv
// Purpose : randomized and directed check of stream_length_finder against a true-length model.
// Latency : expects the result one edge after the terminating word is accepted.
// Backpressure: holds len_ready low for a few cycles and offers junk words during HOLD.
module tb_stream_length_finder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, len_valid, len_ready, overflow;
    logic [63:0] in_word;
    logic [7:0]  length;

    logic        in2_valid, in2_ready, len2_valid, len2_ready, overflow2;
    logic [31:0] in2_word;
    logic [5:0]  length2;

    int total = 0;
    int bad   = 0;

    logic [63:0] wq[$];

    always #5 clk = ~clk;

    stream_length_finder #(.BYTES(8), .LEN_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .len_valid(len_valid), .len_ready(len_ready),
        .length(length), .overflow(overflow)
    );

    stream_length_finder #(.BYTES(4), .LEN_W(6)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_word(in2_word),
        .len_valid(len2_valid), .len_ready(len2_ready),
        .length(length2), .overflow(overflow2)
    );

    // True (unbounded) number of bytes before the first zero byte of the stream.
    function automatic int true_len(input logic [63:0] w[$], input int nb);
        int cnt  = 0;
        bit done = 0;
        foreach (w[i]) begin
            for (int k = 0; k < nb; k++) begin
                if (!done) begin
                    if (w[i][8*k +: 8] == 8'h00) done = 1;
                    else cnt++;
                end
            end
        end
        return cnt;
    endfunction

    function automatic int expect_len(input int cnt, input int lw);
        int maxv = (1 << lw) - 1;
`ifdef STREAM_LEN_SATURATE_EN
        return (cnt > maxv) ? maxv : cnt;
`else
        return cnt % (1 << lw);
`endif
    endfunction

    function automatic bit expect_ovf(input int cnt, input int lw);
`ifdef STREAM_LEN_SATURATE_EN
        return cnt > ((1 << lw) - 1);
`else
        return (cnt < 0) && (lw < 0);
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Streams wq one word per cycle, checks the result, holds it for 'hold' cycles, takes it.
    task automatic run_string(input string tag, input int hold);
        int cnt, el;
        bit eo;
        cnt = true_len(wq, 8);
        el  = expect_len(cnt, 8);
        eo  = expect_ovf(cnt, 8);
        len_ready = 1'b0;
        foreach (wq[i]) begin
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s in_ready before word %0d: got %b want 1", tag, i, in_ready);
            end
            in_valid = 1'b1;
            in_word  = wq[i];
            step;
            if (i < wq.size() - 1) begin
                total++;
                if (len_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early len_valid after word %0d: got %b want 0", tag, i, len_valid);
                end
            end
        end
        // Junk offered during HOLD must never be consumed (it would lengthen the next string).
        in_word = 64'h1111_1111_1111_1111;
        for (int c = 0; c <= hold; c++) begin
            total++;
            if (len_valid !== 1'b1 || length !== 8'(el) || overflow !== eo || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s result cycle %0d: got v=%b len=%0d ovf=%b rdy=%b want v=1 len=%0d ovf=%b rdy=0",
                         tag, c, len_valid, length, overflow, in_ready, el, eo);
            end
            if (c < hold) step;
        end
        len_ready = 1'b1;
        step;
        in_valid  = 1'b0;
        len_ready = 1'b0;
        total++;
        if (len_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s after transfer: got v=%b rdy=%b ovf=%b want v=0 rdy=1 ovf=0",
                     tag, len_valid, in_ready, overflow);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; len_ready = 1'b0; in_word = '0;
        in2_valid = 1'b0; len2_ready = 1'b0; in2_word = '0;
        step;
        step;
        total++;
        if (in_ready !== 1'b0 || in2_ready !== 1'b0 || len_valid !== 1'b0 || length !== 8'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b rdy2=%b v=%b len=%0d ovf=%b want 0 0 0 0 0",
                     in_ready, in2_ready, len_valid, length, overflow);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || len_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, len_valid);
        end
    endtask

    task automatic test_single;
        logic [63:0] singles[4] = '{64'hAABBCCDDEEFFAA00, 64'hAABBCCDDEEFF00AA,
                                    64'hAABBCC00EE00FFAA, 64'h0000000000000000};
        for (int i = 0; i < 4; i++) begin
            wq.delete();
            wq.push_back(singles[i]);
            run_string("single", 0);
        end
    endtask

    task automatic test_multi_word;
        wq.delete();
        wq.push_back(64'hAABBCCDDEEFFAA99);
        wq.push_back(64'h00BBCC00EE44FFAA);
        run_string("multi_word", 0);
    endtask

    task automatic test_backpressure;
        wq.delete();
        wq.push_back(64'h0102030405060708);
        wq.push_back(64'hFF00FF00FF00FFFF);
        run_string("backpressure", 3);
        // Any junk consumed during HOLD would show up as extra length here.
        wq.delete();
        wq.push_back(64'hAABBCCDDEEFF00AA);
        run_string("after_backpressure", 0);
    endtask

    task automatic test_overflow;
        wq.delete();
        for (int i = 0; i < 32; i++) wq.push_back(64'h1111111111111111);
        wq.push_back(64'h1111111111111100);
        run_string("overflow", 1);
        wq.delete();
        wq.push_back(64'h1111110011111111);
        run_string("after_overflow", 0);
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        in_word  = 64'h0102030405060708;
        step;
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        total++;
        if (len_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid during rst: got v=%b rdy=%b want 0 0", len_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        wq.delete();
        wq.push_back(64'hAABBCCDDEEFF00AA);
        run_string("reset_mid", 0);
        // Reset while a result is pending must drop it.
        in_valid = 1'b1;
        in_word  = 64'h0000000000000300;
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        total++;
        if (len_valid !== 1'b0 || in_ready !== 1'b1 || length !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: got v=%b rdy=%b len=%0d want v=0 rdy=1 len=0", len_valid, in_ready, length);
        end
    endtask

    task automatic test_narrow;
        logic [63:0] nq[$];
        int el;
        nq.push_back(64'h11223344);
        nq.push_back(64'h55000066);
        el = expect_len(true_len(nq, 4), 6);
        len2_ready = 1'b1;
        in2_valid  = 1'b1;
        in2_word   = 32'h11223344;
        step;
        in2_word   = 32'h55000066;
        step;
        in2_valid  = 1'b0;
        total++;
        if (len2_valid !== 1'b1 || length2 !== 6'(el) || in2_ready !== 1'b0) begin
            bad++;
            $display("FAIL narrow: got v=%b len=%0d rdy=%b want v=1 len=%0d rdy=0", len2_valid, length2, in2_ready, el);
        end
        step;
        len2_ready = 1'b0;
        total++;
        if (len2_valid !== 1'b0 || in2_ready !== 1'b1) begin
            bad++;
            $display("FAIL narrow_transfer: got v=%b rdy=%b want v=0 rdy=1", len2_valid, in2_ready);
        end
    endtask

    task automatic test_random;
        logic [63:0] w;
        int nw;
        for (int s = 0; s < 40; s++) begin
            nw = (s % 10 == 9) ? $urandom_range(30, 40) : $urandom_range(1, 4);
            wq.delete();
            for (int i = 0; i < nw - 1; i++) begin
                for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'($urandom_range(1, 255));
                wq.push_back(w);
            end
            for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
            w[8*$urandom_range(0, 7) +: 8] = 8'h00;
            wq.push_back(w);
            run_string("random", $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi_word;
        test_backpressure;
        test_overflow;
        test_reset_mid;
        test_narrow;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
